// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and default sizing for the systolic array operand path.
package systolic_pkg;
    typedef enum logic {ROW = 1'b0, COL = 1'b1} mode_e;
    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_e;
    localparam int N_DEF = 4;
    localparam int DW_DEF = 16;
    localparam int K_MAX_DEF = 16;
endpackage

// File: rtl/operand_bank.sv
// operand_bank: N*K_MAX-word register array, one write port, N combinational read ports.
module operand_bank
    import systolic_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int DW = DW_DEF,
    parameter int K_MAX = K_MAX_DEF,
    parameter int AW = $clog2(N * K_MAX)
) (
    input  logic                   i_clk,
    input  logic                   i_we,
    input  logic [AW-1:0]          i_waddr,
    input  logic [DW-1:0]          i_wdata,
    input  logic [N-1:0][AW-1:0]   i_raddr,
    output logic [N-1:0][DW-1:0]   o_rdata
);
    logic [DW-1:0] r_mem [N*K_MAX];

    always_ff @(posedge i_clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < N; i++) o_rdata[i] = r_mem[i_raddr[i]];
    end
endmodule

// File: rtl/operand_stream_buffer.sv
// operand_stream_buffer: ping-pong operand store streaming a matrix onto N skewed lanes.
module operand_stream_buffer
    import systolic_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int DW = DW_DEF,
    parameter int K_MAX = K_MAX_DEF,
    parameter int AW = $clog2(N * K_MAX),
    parameter int KW = $clog2(K_MAX) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_wr_en,
    input  logic [AW-1:0]        i_wr_addr,
    input  logic signed [DW-1:0] i_wr_data,
    input  logic                 i_wr_commit,
    output logic                 o_wr_ready,
    input  logic                 i_mode,
    input  logic [KW-1:0]        i_k_len,
    input  logic                 i_start,
    input  logic                 i_stall,
    input  logic                 i_stop,
    output logic [N*DW-1:0]      o_lane_data,
    output logic [N-1:0]         o_lane_valid,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_stream_ready,
    output logic                 o_err
);
    localparam int DEPTH = N * K_MAX;
    localparam int TW = $clog2(K_MAX + N);

    state_e               r_state, w_state_nxt;
    mode_e                r_mode;
    logic [KW-1:0]        r_klen, w_klen_c;
    logic [TW-1:0]        r_t;
    logic [1:0]           r_full;
    logic                 r_fill_sel, r_stream_sel, r_done, r_err;
    logic [N*DW-1:0]      r_lane_data, w_lane_data;
    logic [N-1:0]         r_lane_valid, w_lane_valid;
    logic [N-1:0][AW-1:0] w_raddr;
    logic [N-1:0][DW-1:0] w_rd0, w_rd1, w_rdata;
    logic                 w_wr_ok, w_commit_ok, w_start_ok, w_bad_start;
    logic                 w_last, w_advance, w_finish, w_abort, w_release, w_hold;

    assign o_wr_ready     = !r_full[r_fill_sel];
    assign o_stream_ready = r_full[r_stream_sel];
    assign o_lane_data    = r_lane_data;
    assign o_lane_valid   = r_lane_valid;
    assign o_busy         = r_state == STREAM;
    assign o_done         = r_done;
    assign o_err          = r_err;

    assign w_wr_ok     = i_wr_en && o_wr_ready && ({1'b0, i_wr_addr} < (AW+1)'(DEPTH));
    assign w_commit_ok = i_wr_commit && o_wr_ready;
    assign w_klen_c    = (i_k_len > KW'(K_MAX)) ? KW'(K_MAX) : i_k_len;
    // a start in the done cycle is neither accepted nor an error
    assign w_start_ok  = r_state == IDLE && i_start && !i_stop && !r_done && o_stream_ready && i_k_len != '0;
    assign w_bad_start = r_state == IDLE && i_start && !i_stop && !r_done && (!o_stream_ready || i_k_len == '0);
    assign w_last      = r_t == TW'(int'(r_klen) + N - 1);
    assign w_advance   = r_state == STREAM && !i_stop && !i_stall;
    assign w_finish    = w_advance && w_last;
    assign w_abort     = r_state == STREAM && i_stop;
    assign w_release   = w_finish || w_abort;
    assign w_hold      = r_state == STREAM && i_stall && !i_stop;
    assign w_rdata     = r_stream_sel ? w_rd1 : w_rd0;

    operand_bank #(.N(N), .DW(DW), .K_MAX(K_MAX), .AW(AW)) u_bank0 (
        .i_clk(i_clk), .i_we(w_wr_ok && !r_fill_sel), .i_waddr(i_wr_addr),
        .i_wdata(i_wr_data), .i_raddr(w_raddr), .o_rdata(w_rd0)
    );
    operand_bank #(.N(N), .DW(DW), .K_MAX(K_MAX), .AW(AW)) u_bank1 (
        .i_clk(i_clk), .i_we(w_wr_ok && r_fill_sel), .i_waddr(i_wr_addr),
        .i_wdata(i_wr_data), .i_raddr(w_raddr), .o_rdata(w_rd1)
    );

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_state <= IDLE;
        else r_state <= w_state_nxt;

    always_comb begin
        w_state_nxt = w_start_ok ? STREAM : w_release ? IDLE : r_state;
    end

    // lane i sees element t-i; the completion step t = k_len+N-1 is all-invalid
    always_comb begin
        w_lane_valid = '0;
        w_raddr = '0;
        for (int i = 0; i < N; i++) begin
            w_lane_valid[i] = r_state == STREAM && int'(r_t) >= i && int'(r_t) - i < int'(r_klen);
            w_raddr[i] = !w_lane_valid[i] ? '0 :
                         r_mode == COL ? AW'((int'(r_t) - i) * N + i) : AW'(i * K_MAX + int'(r_t) - i);
        end
    end

    always_comb begin
        w_lane_data = '0;
        for (int i = 0; i < N; i++) w_lane_data[i*DW +: DW] = w_lane_valid[i] ? w_rdata[i] : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode       <= ROW;
            r_klen       <= '0;
            r_t          <= '0;
            r_full       <= '0;
            r_fill_sel   <= 1'b0;
            r_stream_sel <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_lane_data  <= '0;
            r_lane_valid <= '0;
        end else begin
            if (w_start_ok) begin
                r_mode <= mode_e'(i_mode);
                r_klen <= w_klen_c;
                r_t    <= '0;
            end else if (w_advance) r_t <= r_t + 1'b1;
            if (!w_hold) begin
                r_lane_data  <= w_abort ? '0 : w_lane_data;
                r_lane_valid <= w_abort ? '0 : w_lane_valid;
            end
            r_done       <= w_finish;
            r_full       <= (r_full | ({1'b0, w_commit_ok} << r_fill_sel)) & ~({1'b0, w_release} << r_stream_sel);
            r_fill_sel   <= r_fill_sel ^ w_commit_ok;
            r_stream_sel <= r_stream_sel ^ w_release;
            r_err        <= !i_stop && (r_err || (i_wr_en && !w_wr_ok) || (i_wr_commit && !o_wr_ready) || w_bad_start);
        end
    end
endmodule

// File: tb/tb_operand_stream_buffer.sv
// tb_operand_stream_buffer: directed scenarios for the ping-pong skewed operand feeder.
module tb_operand_stream_buffer;
    localparam int N = 4, DW = 16, K_MAX = 16, AW = 6, KW = 5;

    logic clk = 1'b0, rst_n = 1'b0;
    logic wr_en = 1'b0, wr_commit = 1'b0, mode = 1'b0, start = 1'b0, stall = 1'b0, stop = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic signed [DW-1:0] wr_data = '0;
    logic [KW-1:0] k_len = '0;
    logic [N*DW-1:0] lane_data;
    logic [N-1:0] lane_valid;
    logic wr_ready, busy, done, stream_ready, err;
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    operand_stream_buffer #(.N(N), .DW(DW), .K_MAX(K_MAX)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_wr_commit(wr_commit), .o_wr_ready(wr_ready), .i_mode(mode), .i_k_len(k_len),
        .i_start(start), .i_stall(stall), .i_stop(stop), .o_lane_data(lane_data),
        .o_lane_valid(lane_valid), .o_busy(busy), .o_done(done), .o_stream_ready(stream_ready), .o_err(err)
    );

    function automatic logic [N*DW-1:0] exp_vec(input int base, input bit col, input int kl, input int t);
        logic [N*DW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            if (t >= i && t - i < kl) v[i*DW +: DW] = DW'(base + (col ? (t - i) * N + i : i * K_MAX + t - i));
        return v;
    endfunction

    function automatic logic [N-1:0] exp_vld(input int kl, input int t);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = t >= i && t - i < kl;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bank(input int base);
        for (int a = 0; a < N * K_MAX; a++) begin
            wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(base + a);
            tick();
        end
        wr_en = 1'b0; wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
    endtask

    task automatic start_stream(input bit m, input int kl);
        mode = m; k_len = KW'(kl); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_vec++;
        if ({lane_data, lane_valid, busy, done, stream_ready, err, wr_ready} !== {{(N*DW+N+4){1'b0}}, 1'b1}) begin
            n_err++;
            $display("FAIL reset: data=%h vld=%b busy=%b done=%b srdy=%b err=%b wrdy=%b, need all 0 and wrdy=1",
                     lane_data, lane_valid, busy, done, stream_ready, err, wr_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_row();
        load_bank(1);
        n_vec++;
        if (stream_ready !== 1'b1 || wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL row_commit: srdy=%b wrdy=%b need 1 1", stream_ready, wr_ready);
        end
        start_stream(1'b0, 4);
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_vec++;
            if (lane_data !== exp_vec(1, 1'b0, 4, e - 1) || lane_valid !== exp_vld(4, e - 1) || done !== (e == 8) || busy !== (e < 8)) begin
                n_err++;
                $display("FAIL row E%0d: data=%h vld=%b done=%b busy=%b need data=%h vld=%b",
                         e, lane_data, lane_valid, done, busy, exp_vec(1, 1'b0, 4, e - 1), exp_vld(4, e - 1));
            end
            if (e == 4) begin
                n_vec++;
                if (lane_data[3*DW +: DW] !== 16'd49) begin
                    n_err++;
                    $display("FAIL row_lane3_E4: got %0d need 49", lane_data[3*DW +: DW]);
                end
            end
        end
        n_vec++;
        if (stream_ready !== 1'b0 || done !== 1'b1) begin
            n_err++;
            $display("FAIL row_release: srdy=%b done=%b need 0 1", stream_ready, done);
        end
    endtask

    task automatic test_col();
        load_bank(1);
        start_stream(1'b1, 16);
        for (int e = 1; e <= 20; e++) begin
            tick();
            n_vec++;
            if (lane_data !== exp_vec(1, 1'b1, 16, e - 1) || lane_valid !== exp_vld(16, e - 1) || done !== (e == 20)) begin
                n_err++;
                $display("FAIL col E%0d: data=%h vld=%b done=%b need data=%h vld=%b",
                         e, lane_data, lane_valid, done, exp_vec(1, 1'b1, 16, e - 1), exp_vld(16, e - 1));
            end
            if (e == 3 || e == 18) begin
                n_vec++;
                if (lane_data[2*DW +: DW] !== ((e == 3) ? 16'd3 : 16'd63)) begin
                    n_err++;
                    $display("FAIL col_lane2_E%0d: got %0d need %0d", e, lane_data[2*DW +: DW], (e == 3) ? 3 : 63);
                end
            end
        end
    endtask

    task automatic test_ping_pong();
        load_bank(200);
        start_stream(1'b0, 16);
        for (int e = 1; e <= 22; e++) begin
            wr_en     = (e <= 8) || (e == 10);
            wr_addr   = (e <= 8) ? AW'(((e - 1) / 2) * K_MAX + (e - 1) % 2) : AW'(63);
            wr_data   = (e <= 8) ? DW'(300 + ((e - 1) / 2) * K_MAX + (e - 1) % 2) : 16'sh7777;
            wr_commit = e == 9;
            start     = e >= 21;
            k_len     = (e >= 21) ? KW'(2) : KW'(16);
            tick();
            if (e <= 20) begin
                n_vec++;
                if (lane_data !== exp_vec(200, 1'b0, 16, e - 1) || done !== (e == 20) || busy !== (e < 20)) begin
                    n_err++;
                    $display("FAIL pp_stream0 E%0d: data=%h done=%b busy=%b need data=%h",
                             e, lane_data, done, busy, exp_vec(200, 1'b0, 16, e - 1));
                end
            end
            if (e == 9 || e == 10) begin
                n_vec++;
                if (wr_ready !== 1'b0 || err !== (e == 10)) begin
                    n_err++;
                    $display("FAIL pp_both_full E%0d: wrdy=%b err=%b need 0 %b", e, wr_ready, err, e == 10);
                end
            end
            if (e >= 21) begin
                n_vec++;
                if (busy !== (e == 22) || done !== 1'b0) begin
                    n_err++;
                    $display("FAIL pp_restart E%0d: busy=%b done=%b need %b 0", e, busy, done, e == 22);
                end
            end
        end
        start = 1'b0; wr_en = 1'b0; wr_commit = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            n_vec++;
            if (lane_data !== exp_vec(300, 1'b0, 2, e - 1) || lane_valid !== exp_vld(2, e - 1) || done !== (e == 6)) begin
                n_err++;
                $display("FAIL pp_stream1 E%0d: data=%h vld=%b done=%b need data=%h",
                         e, lane_data, lane_valid, done, exp_vec(300, 1'b0, 2, e - 1));
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_vec++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL pp_err_clear: err=%b need 0", err);
        end
    endtask

    task automatic test_stall();
        int s;
        load_bank(1);
        start_stream(1'b0, 4);
        for (int e = 1; e <= 11; e++) begin
            stall = e >= 4 && e <= 6;
            tick();
            s = (e <= 3) ? e - 1 : (e <= 6) ? 2 : e - 4;
            n_vec++;
            if (lane_data !== exp_vec(1, 1'b0, 4, s) || lane_valid !== exp_vld(4, s) || done !== (e == 11) || busy !== (e < 11)) begin
                n_err++;
                $display("FAIL stall E%0d: data=%h vld=%b done=%b busy=%b need data=%h vld=%b",
                         e, lane_data, lane_valid, done, busy, exp_vec(1, 1'b0, 4, s), exp_vld(4, s));
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_stop();
        load_bank(500);
        start_stream(1'b0, 4);
        for (int e = 1; e <= 8; e++) begin
            stop = e == 5;
            tick();
            n_vec++;
            if (lane_data !== exp_vec(500, 1'b0, (e <= 4) ? 4 : 0, e - 1) || lane_valid !== exp_vld((e <= 4) ? 4 : 0, e - 1)
                || done !== 1'b0 || busy !== (e < 5)) begin
                n_err++;
                $display("FAIL stop E%0d: data=%h vld=%b done=%b busy=%b", e, lane_data, lane_valid, done, busy);
            end
        end
        stop = 1'b0;
        n_vec++;
        if (stream_ready !== 1'b0 || wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stop_release: srdy=%b wrdy=%b need 0 1", stream_ready, wr_ready);
        end
    endtask

    task automatic test_bad_start();
        start_stream(1'b0, 4);
        n_vec++;
        if (busy !== 1'b0 || err !== 1'b1) begin
            n_err++;
            $display("FAIL bad_start_empty: busy=%b err=%b need 0 1", busy, err);
        end
        stop = 1'b1; tick(); stop = 1'b0;
        n_vec++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL bad_start_clear1: err=%b need 0", err);
        end
        load_bank(600);
        start_stream(1'b0, 0);
        n_vec++;
        if (busy !== 1'b0 || err !== 1'b1 || stream_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bad_start_klen0: busy=%b err=%b srdy=%b need 0 1 1", busy, err, stream_ready);
        end
        stop = 1'b1; tick(); stop = 1'b0;
        n_vec++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL bad_start_clear2: err=%b need 0", err);
        end
    endtask

    task automatic test_clamp();
        start_stream(1'b0, 20);
        for (int e = 1; e <= 20; e++) begin
            tick();
            n_vec++;
            if (lane_data !== exp_vec(600, 1'b0, 16, e - 1) || done !== (e == 20) || busy !== (e < 20)) begin
                n_err++;
                $display("FAIL clamp E%0d: data=%h done=%b busy=%b need data=%h",
                         e, lane_data, done, busy, exp_vec(600, 1'b0, 16, e - 1));
            end
        end
    endtask

    task automatic test_reset_mid();
        load_bank(1);
        start_stream(1'b0, 16);
        tick();
        tick();
        n_vec++;
        if (busy !== 1'b1 || stream_ready !== 1'b1 || lane_valid === '0) begin
            n_err++;
            $display("FAIL mid_pre: busy=%b srdy=%b vld=%b", busy, stream_ready, lane_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({lane_data, lane_valid, busy, done, stream_ready, err, wr_ready} !== {{(N*DW+N+4){1'b0}}, 1'b1}) begin
            n_err++;
            $display("FAIL mid_reset: data=%h vld=%b busy=%b done=%b srdy=%b err=%b wrdy=%b",
                     lane_data, lane_valid, busy, done, stream_ready, err, wr_ready);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_row();
        test_col();
        test_ping_pong();
        test_stall();
        test_stop();
        test_bad_start();
        test_clamp();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/operand_stream_buffer.md
# operand_stream_buffer

Parametrised, double-buffered operand feeder for the systolic array. It holds one operand matrix (A or B) per bank in two ping-pong banks, so the next tile can be loaded while the current one streams. It streams the matrix onto N lanes with diagonal skew: lane i is delayed i cycles. It sits between the host write path and the array edge, and generalises the fixed 4-lane, 64-word feeder with these additions: configurable lane count and depth, runtime stream length, row/column addressing, stall support, and error reporting.

## Interface
- N, 4, lane count (array dimension).
- DW, 16, signed data width.
- K_MAX, 16, maximum stream length per lane. Each bank holds N*K_MAX words.
- AW, $clog2(N*K_MAX), write address width (derived).
- KW, $clog2(K_MAX)+1, width of k_len (derived).
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous assert, synchronous deassert, active-low.
- wr_en  in  1  write strobe into the fill bank.
- wr_addr  in  AW  word address.
- wr_data  in  DW  signed write data.
- wr_commit  in  1  pulse; marks the fill bank full.
- wr_ready  out  1  the fill bank is empty and writable.
- mode  in  1  addressing mode, sampled at start. 0 = ROW, 1 = COL.
- k_len  in  KW  stream length, sampled at start.
- start  in  1  request to stream the stream bank.
- stall  in  1  freezes streaming.
- stop  in  1  synchronous abort; also clears err.
- lane_data  out  N*DW  lane i occupies bits [i*DW +: DW].
- lane_valid  out  N  per-lane valid.
- busy  out  1  the FSM is in STREAM.
- done  out  1  one-cycle pulse at stream completion.
- stream_ready  out  1  the stream bank is full.
- err  out  1  sticky protocol-violation flag.

## Operation
- State: two banks, flags full[1:0], pointers fill_sel and stream_sel. All reset to 0.
- Writes:
  - A write is performed when wr_en && wr_ready && wr_addr < N*K_MAX; the word goes to bank[fill_sel][wr_addr].
  - Otherwise the write is dropped. A dropped write with wr_en high sets err.
- Commit:
  - wr_commit with wr_ready high sets full[fill_sel] and toggles fill_sel.
  - wr_commit with wr_ready low is ignored and sets err.
- FSM has two states, IDLE and STREAM.
- IDLE → STREAM when all of these hold: start, !stop, full[stream_sel], k_len != 0.
  - On entry, latch mode and k_len. k_len values above K_MAX are clamped to K_MAX.
  - On entry, set step counter t = 0.
  - A start that fails only on the empty bank or k_len == 0 is ignored and sets err.
- STREAM, each non-stalled cycle:
  - Present step t.
  - Lane i is valid iff i ≤ t < i + k_len, with element k = t − i.
  - Data address: ROW uses i*K_MAX + k; COL uses k*N + i.
  - Invalid lanes drive data 0.
- Completion: after step T = k_len + N − 2:
  - Return to IDLE and pulse done.
  - Clear full[stream_sel] and toggle stream_sel.
- stall high in STREAM: t, lane_data and lane_valid hold their values. A stall in IDLE has no effect.
- stop in STREAM:
  - Next cycle: IDLE with all valids 0.
  - Clear full[stream_sel] and toggle stream_sel.
  - No done pulse.
- Priorities:
  - stop beats start and stall.
  - A commit on the fill bank and a completion on the stream bank in the same cycle both take effect.
  - A start in the same cycle as done is not accepted; accept it on the following cycle.
- Reset:
  - All outputs are 0.
  - wr_ready = 1.
  - Memory contents are not reset.

## Timing
- Accepted start at edge E0 → step 0 becomes visible after E1. Step t is visible after E(1+t), excluding stall cycles.
- Last step is visible after E(1+T). After E(2+T): done = 1, all valids 0, busy = 0, stream_ready updated.
- Outputs are registered. Bank reads are combinational from the register array into the output register.
- wr_ready and stream_ready reflect their flags with no extra latency. A write is legal in the cycle immediately after a commit if the new fill bank is empty.

## Structure
- systolic_pkg holds:
  - mode_e (ROW, COL).
  - state_e (IDLE, STREAM).
  - Default constants for N, DW, K_MAX.
- Sub-module operand_bank: one register array of N*K_MAX × DW words, with 1 write port and N combinational read ports. It is instantiated twice.

## Test plan
- Reset: assert rst low mid-stream → all outputs 0, wr_ready = 1, stream_ready = 0 immediately.
- ROW stream (N = 4, K_MAX = 16): load bank0 with addr+1, commit, start with k_len = 4.
  - Lane0 shows 1, 2, 3, 4 after E1–E4.
  - Lane1 shows 17–20 after E2–E5.
  - Lane3 shows 49–52 after E4–E7.
  - done pulses after E8.
- COL stream: same data, k_len = 16 → lane2 shows 3, 7, 11, …, 63, starting after E3.
- Ping-pong:
  - Stream bank0 while loading and committing bank1 → second start is accepted the cycle after done.
  - A write while both banks are full → dropped and err = 1.
- Stall and stop:
  - stall for 3 cycles at t = 2 → outputs are held and done is delayed by 3 cycles.
  - stop at t = 3 → valids go to 0 the next cycle, no done, and the bank is freed.
- Bad start: start with k_len = 0, or with an empty bank → stays IDLE and err = 1. A subsequent stop clears err.
